// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: CHANNELS independent square-wave outputs with tick strobes.
// Optional macro CLK_DIV_MULTI_TICK_EN enables the tick registers; without it tick is tied low.
module clk_div_multi #(
    parameter int          CHANNELS    = 4,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*CNT_W-1:0] div_value,
    input  logic [CHANNELS-1:0]       load,
    input  logic                      sync_restart,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       tick
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] last_cnt;
        logic             clk_q;
        logic             restart;
        logic             terminal;

        // A divide value of 0 behaves like 1: terminal count is 0 either way.
        assign last_cnt = (div_q == '0) ? '0 : div_q - CNT_W'(1);
        assign restart  = sync_restart | load[i];
        assign terminal = (cnt_q == last_cnt);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                div_q <= DEF_DIV;
                cnt_q <= '0;
                clk_q <= 1'b0;
            end else if (restart) begin
                if (load[i]) begin
                    div_q <= div_value[i*CNT_W +: CNT_W];
                end
                cnt_q <= '0;
                clk_q <= 1'b0;
            end else if (en[i]) begin
                if (terminal) begin
                    cnt_q <= '0;
                    clk_q <= ~clk_q;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign clk_out[i] = clk_q;

`ifdef CLK_DIV_MULTI_TICK_EN
        logic tick_q;

        // Tick coincides with the toggle of clk_q, so it uses the same condition.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= ~restart & en[i] & terminal;
            end
        end

        assign tick[i] = tick_q;
`else
        assign tick[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with two 8-bit channels and a default divide of 4.
module tb_clk_div_multi;

    localparam int CH = 2;
    localparam int W  = 8;
`ifdef CLK_DIV_MULTI_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [CH-1:0]     en;
    logic [CH*W-1:0]   div_value;
    logic [CH-1:0]     load;
    logic              sync_restart;
    logic [CH-1:0]     clk_out;
    logic [CH-1:0]     tick;

    int checks = 0;
    int errors = 0;

    clk_div_multi #(
        .CHANNELS    (CH),
        .CNT_W       (W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .div_value    (div_value),
        .load         (load),
        .sync_restart (sync_restart),
        .clk_out      (clk_out),
        .tick         (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [CH-1:0] tk(input logic [CH-1:0] v);
        return TICK_ON ? v : '0;
    endfunction

    initial begin
        reset        = 1'b1;
        en           = '0;
        div_value    = '0;
        load         = '0;
        sync_restart = 1'b0;

        // Reset state
        cyc(2);
        chk("rst_clk", clk_out, 2'b00);
        chk("rst_tick", tick, 2'b00);

        // Reset release, N=4 on both channels
        reset = 1'b0;
        en    = 2'b11;
        cyc(3);
        chk("e3_clk", clk_out, 2'b00);
        chk("e3_tick", tick, tk(2'b00));
        cyc(1);
        chk("e4_clk", clk_out, 2'b11);
        chk("e4_tick", tick, tk(2'b11));
        cyc(1);
        chk("e5_clk", clk_out, 2'b11);
        chk("e5_tick", tick, tk(2'b00));
        cyc(3);
        chk("e8_clk", clk_out, 2'b00);
        chk("e8_tick", tick, tk(2'b11));
        cyc(4);
        chk("e12_clk", clk_out, 2'b11);
        chk("e12_tick", tick, tk(2'b11));

        // Load channel 1 with 3 at cnt=2
        cyc(2);
        load      = 2'b10;
        div_value = {8'd3, 8'd0};
        cyc(1);
        chk("ld_clk", clk_out, 2'b01);
        chk("ld_tick", tick, tk(2'b00));
        load = 2'b00;
        cyc(1);
        chk("e16_clk", clk_out, 2'b00);
        chk("e16_tick", tick, tk(2'b01));
        cyc(1);
        chk("e17_clk", clk_out, 2'b00);
        cyc(1);
        chk("e18_clk", clk_out, 2'b10);
        chk("e18_tick", tick, tk(2'b10));
        cyc(1);
        chk("e19_tick", tick, tk(2'b00));
        cyc(1);
        chk("e20_clk", clk_out, 2'b11);
        chk("e20_tick", tick, tk(2'b01));
        cyc(1);
        chk("e21_clk", clk_out, 2'b01);
        chk("e21_tick", tick, tk(2'b10));

        // Divide by 0 on ch0 and 1 on ch1
        load      = 2'b11;
        div_value = {8'd1, 8'd0};
        cyc(1);
        chk("n01_ld_clk", clk_out, 2'b00);
        load = 2'b00;
        cyc(1);
        chk("n01_a_clk", clk_out, 2'b11);
        chk("n01_a_tick", tick, tk(2'b11));
        cyc(1);
        chk("n01_b_clk", clk_out, 2'b00);
        chk("n01_b_tick", tick, tk(2'b11));
        cyc(1);
        chk("n01_c_clk", clk_out, 2'b11);

        // Pause ch0 at cnt=1 with N=4
        load      = 2'b11;
        div_value = {8'd4, 8'd4};
        cyc(1);
        chk("p_ld_clk", clk_out, 2'b00);
        load = 2'b00;
        cyc(1);
        en = 2'b10;
        cyc(3);
        chk("p_mid_clk", clk_out, 2'b10);
        chk("p_mid_tick", tick, tk(2'b10));
        cyc(2);
        chk("p_end_clk", clk_out, 2'b10);
        chk("p_end_tick", tick, tk(2'b00));
        en = 2'b11;
        cyc(2);
        chk("p_r2_clk", clk_out, 2'b00);
        chk("p_r2_tick", tick, tk(2'b10));
        cyc(1);
        chk("p_r3_clk", clk_out, 2'b01);
        chk("p_r3_tick", tick, tk(2'b01));

        // N=3 / N=5 out of phase, then sync_restart with load[1]=6
        load      = 2'b11;
        div_value = {8'd5, 8'd3};
        cyc(1);
        load = 2'b00;
        cyc(3);
        chk("s_pre_clk", clk_out, 2'b01);
        cyc(1);
        sync_restart = 1'b1;
        load         = 2'b10;
        div_value    = {8'd6, 8'd9};
        cyc(1);
        chk("s_clk", clk_out, 2'b00);
        chk("s_tick", tick, tk(2'b00));
        sync_restart = 1'b0;
        load         = 2'b00;
        cyc(2);
        chk("s2_clk", clk_out, 2'b00);
        cyc(1);
        chk("s3_clk", clk_out, 2'b01);
        chk("s3_tick", tick, tk(2'b01));
        cyc(2);
        chk("s5_clk", clk_out, 2'b01);
        chk("s5_tick", tick, tk(2'b00));
        cyc(1);
        chk("s6_clk", clk_out, 2'b10);
        chk("s6_tick", tick, tk(2'b11));

        // Asynchronous reset mid-period, then default divide restored
        cyc(1);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_clk", clk_out, 2'b00);
        chk("ar_tick", tick, 2'b00);
        cyc(1);
        reset = 1'b0;
        cyc(3);
        chk("ar3_clk", clk_out, 2'b00);
        cyc(1);
        chk("ar4_clk", clk_out, 2'b11);
        chk("ar4_tick", tick, tk(2'b11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
